cnn_cell_update: RTL and testbench
==================================

Name: cnn_cell_update

Overview:
- Consumes the per-cell template sums (17-bit signed A*Y + B*U + I results) streamed from the template-equation stage.
- Integrates each cell's state with a forward-Euler step and produces the saturated 9-bit signed cell output Y that is fed back as the next iteration's Y neighbourhood.
- Owns the cell-state memory and the iteration sequencing: clear, sweep, convergence detection and done.

Parameters:
- NUM_CELLS, 64, number of cells in the array.
- IDX_W, 6, cell index width; must satisfy 2**IDX_W >= NUM_CELLS.
- X_W, 20, signed cell-state width.
- DT_SHIFT, 3, Euler step size; dt = 2^-DT_SHIFT.
- Y_ONE, 128, unity output level; Y saturates to [-Y_ONE, +Y_ONE].
- TOL, 2, convergence tolerance on |delta|.
- MAX_ITER, 255, sweep limit; 8-bit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; honoured only in IDLE or DONE.
- in_valid  in  1  template sum valid.
- in_ready  out  1  block can accept a sum.
- in_idx  in  IDX_W  cell index of the sum.
- in_sum  in  17  signed template sum.
- in_last  in  1  last cell of the current sweep.
- y_valid  out  1  output valid.
- y_ready  in  1  downstream accepts output.
- y_idx  out  IDX_W  cell index of the output.
- y_out  out  9  signed saturated cell output.
- iter_count  out  8  completed sweeps.
- converged  out  1  last completed sweep met TOL.
- busy  out  1  block is in CLEAR or RUN.
- done  out  1  block is in DONE.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - in_ready, y_valid, busy, done, converged = 0.
  - iter_count, y_idx, y_out = 0; clear pointer = 0.
  - The state memory is not reset.
- FSM transitions:
  - IDLE -> CLEAR on start.
  - CLEAR writes 0 to x[0..NUM_CELLS-1], one cell per cycle (NUM_CELLS cycles), then goes to RUN.
  - Entering CLEAR zeroes iter_count and converged.
  - RUN -> DONE on an accepted in_last when the sweep converged or iter_count+1 == MAX_ITER.
  - Otherwise RUN stays in RUN.
  - DONE -> CLEAR on start.
  - start is ignored in CLEAR and RUN.
- Handshake:
  - in_ready = (FSM == RUN) && (!y_valid || y_ready).
  - A transfer occurs when in_valid && in_ready.
  - The y output register loads on a transfer. y_valid clears when y_ready is high and no new transfer occurs.
  - y_idx and y_out must hold stable while y_valid && !y_ready.
  - Latency from transfer to y_valid is 1 cycle; throughput is 1 per cycle.
- Arithmetic, per transfer:
  - x = combinational read of x[in_idx].
  - diff = sext(in_sum) - x, computed at X_W+1 bits.
  - delta = diff >>> DT_SHIFT (arithmetic shift, rounds toward -inf).
  - x_new = x + delta, saturated to the signed X_W range.
  - x[in_idx] is written with x_new on the same edge.
  - y_out = clamp(x_new, -Y_ONE, +Y_ONE), truncated to 9 bits.
- Hazards: back-to-back transfers to the same idx must see the previous write. The combinational read plus write-on-edge gives this with no forwarding.
- Out-of-range index (in_idx >= NUM_CELLS):
  - The transfer is accepted and x is treated as 0.
  - No memory write occurs.
  - y is produced normally and the index is excluded from the convergence check.
- Convergence:
  - A sweep flag is set at sweep start.
  - The flag clears on any transfer with |delta| > TOL.
  - On an accepted in_last: iter_count increments (saturating at 255) and converged <= the flag (including this transfer's delta). The flag is then re-armed.
- Reset mid-operation: all control state returns to its reset values immediately. Memory contents are undefined until the next CLEAR; no output is produced before that CLEAR.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, CLEAR, RUN, DONE).
  - Template-sum width constant (17).
  - Cell-output width constant (9).
  - A saturate/clamp function used for both the X_W and ±Y_ONE limits.
- Sub-module cnn_state_mem: NUM_CELLS x X_W register array with one combinational read port and one synchronous write port, muxed between the clear pointer and in_idx.

Test Plan:
- Sum sequence on idx 0 after start and CLEAR (DT_SHIFT=3, Y_ONE=128); each row is a separate check:
  - CLEAR takes exactly 64 cycles with busy=1 and in_ready=0; then idx0 sum=800 -> y_out=100 one cycle later, y_idx=0.
  - Second sum=800 on idx0 -> x=187, y_out=128 (saturated).
  - sum=-9 on a fresh cell -> delta=-2, y_out=-2.
- Sweep of 64 cells, all sum=0 after CLEAR, in_last on idx63 -> iter_count=1, converged=1, done=1 next cycle, in_ready=0.
- MAX_ITER=2, repeated sweeps of sum=16000 -> done after sweep 2 with converged=0 and iter_count=2.
- Backpressure: hold y_ready=0 with y_valid=1 -> in_ready=0, y_out/y_idx stable for 10 cycles; release -> next transfer resumes with no loss or duplication.
- Assert rst mid-sweep -> all outputs at reset values immediately; next start re-clears memory (first sum=800 yields y_out=100 again).
- in_idx=63 back-to-back twice with sum=800 -> second y_out=128, proving read-after-write; in_idx beyond NUM_CELLS (with IDX_W widened) yields y from x=0.

Source files
------------

// File: rtl/cnn_cell_update_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_cell_update_pkg
// Description : Shared types, widths and the saturation helper for the CNN
//               cell-update stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_cell_update_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int c_SUM_W = 17;
    localparam int c_Y_W   = 9;

    // Callers sign-extend to 32 bits so one clamp serves both the state and output limits.
    function automatic logic signed [31:0] sat_s32(
        input logic signed [31:0] v,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        logic signed [31:0] r;
        r = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_state_mem.sv
`default_nettype none
// ============================================================================
// Module      : cnn_state_mem
// Description : Cell-state register array, one combinational read port and one
//               synchronous write port shared by the clear sweep and updates.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_state_mem #(
    parameter int NUM_CELLS = 64,
    parameter int IDX_W     = 6,
    parameter int X_W       = 20
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic [IDX_W-1:0] i_clr_ptr,
    input  logic             i_upd_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [X_W-1:0]   i_upd_data,
    output logic [X_W-1:0]   o_rd_data,
    output logic             o_rd_valid
);

    localparam int               c_AW  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [IDX_W:0]   c_NUM = (IDX_W + 1)'(NUM_CELLS);

    logic [X_W-1:0]   r_mem_q [NUM_CELLS];
    logic [IDX_W-1:0] w_wr_addr;
    logic [X_W-1:0]   w_wr_data;
    logic             w_wr_ok;
    logic             w_we;

    assign o_rd_valid = ({1'b0, i_idx} < c_NUM);
    assign o_rd_data  = o_rd_valid ? r_mem_q[i_idx[c_AW-1:0]] : '0;

    assign w_wr_addr = i_clear ? i_clr_ptr : i_idx;
    assign w_wr_data = i_clear ? '0 : i_upd_data;
    assign w_wr_ok   = ({1'b0, w_wr_addr} < c_NUM);
    assign w_we      = (i_clear || i_upd_we) && w_wr_ok;

    // Contents are deliberately not reset; a clear sweep initialises them.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_q[w_wr_addr[c_AW-1:0]] <= w_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_cell_update.sv
`default_nettype none
// ============================================================================
// Module      : cnn_cell_update
// Description : Forward-Euler cell-state integration, saturated Y output and
//               clear / sweep / convergence sequencing for a CNN array.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_cell_update
    import cnn_cell_update_pkg::*;
#(
    parameter int NUM_CELLS = 64,
    parameter int IDX_W     = 6,
    parameter int X_W       = 20,
    parameter int DT_SHIFT  = 3,
    parameter int Y_ONE     = 128,
    parameter int TOL       = 2,
    parameter int MAX_ITER  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic [c_SUM_W-1:0] in_sum,
    input  logic               in_last,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [IDX_W-1:0]   y_idx,
    output logic [c_Y_W-1:0]   y_out,
    output logic [7:0]         iter_count,
    output logic               converged,
    output logic               busy,
    output logic               done
);

    localparam logic signed [31:0] c_X_MAX    = (32'sd1 <<< (X_W - 1)) - 32'sd1;
    localparam logic signed [31:0] c_X_MIN    = -(32'sd1 <<< (X_W - 1));
    localparam logic signed [31:0] c_Y_MAX    = 32'(Y_ONE);
    localparam logic signed [31:0] c_Y_MIN    = -c_Y_MAX;
    localparam logic signed [31:0] c_TOL_P    = 32'(TOL);
    localparam logic signed [31:0] c_TOL_N    = -c_TOL_P;
    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_CELLS - 1);
    localparam logic [8:0]         c_MAX_ITER = 9'(MAX_ITER);

    state_e             r_state_q,   w_state_d;
    logic [IDX_W-1:0]   r_clr_ptr_q, w_clr_ptr_d;
    logic [7:0]         r_iter_q,    w_iter_d;
    logic               r_conv_q,    w_conv_d;
    logic               r_flag_q,    w_flag_d;
    logic               r_y_valid_q, w_y_valid_d;
    logic [IDX_W-1:0]   r_y_idx_q,   w_y_idx_d;
    logic [c_Y_W-1:0]   r_y_out_q,   w_y_out_d;
    logic               r_busy_q,    w_busy_d;
    logic               r_done_q,    w_done_d;

    logic [X_W-1:0]     w_x_rd;
    logic               w_idx_ok;
    logic               w_xfer;
    logic               w_flag_after;
    logic               w_big_step;
    logic signed [X_W:0] w_x_ext;
    logic signed [X_W:0] w_sum_ext;
    logic signed [X_W:0] w_diff;
    logic signed [X_W:0] w_delta;
    logic signed [X_W:0] w_x_sum;
    logic signed [31:0] w_delta32;
    logic signed [31:0] w_x_sat32;
    logic signed [31:0] w_y_sat32;
    logic [X_W-1:0]     w_x_new;
    logic [c_Y_W-1:0]   w_y_new;
    logic               w_unused_bits;

    cnn_state_mem #(
        .NUM_CELLS (NUM_CELLS),
        .IDX_W     (IDX_W),
        .X_W       (X_W)
    ) u_state_mem (
        .clk        (clk),
        .i_clear    (r_state_q == S_CLEAR),
        .i_clr_ptr  (r_clr_ptr_q),
        .i_upd_we   (w_xfer),
        .i_idx      (in_idx),
        .i_upd_data (w_x_new),
        .o_rd_data  (w_x_rd),
        .o_rd_valid (w_idx_ok)
    );

    assign in_ready = (r_state_q == S_RUN) && (!r_y_valid_q || y_ready);
    assign w_xfer   = in_valid && in_ready;

    // One guard bit keeps sum - x exact; the shift floors toward -inf.
    assign w_x_ext   = {w_x_rd[X_W-1], w_x_rd};
    assign w_sum_ext = {{(X_W + 1 - c_SUM_W){in_sum[c_SUM_W-1]}}, in_sum};
    assign w_diff    = w_sum_ext - w_x_ext;
    assign w_delta   = w_diff >>> DT_SHIFT;
    assign w_x_sum   = w_x_ext + w_delta;

    assign w_delta32 = {{(31 - X_W){w_delta[X_W]}}, w_delta};
    assign w_x_sat32 = sat_s32({{(31 - X_W){w_x_sum[X_W]}}, w_x_sum}, c_X_MIN, c_X_MAX);
    assign w_y_sat32 = sat_s32(w_x_sat32, c_Y_MIN, c_Y_MAX);
    assign w_x_new   = w_x_sat32[X_W-1:0];
    assign w_y_new   = w_y_sat32[c_Y_W-1:0];
    assign w_unused_bits = ^{w_x_sat32[31:X_W], w_y_sat32[31:c_Y_W]};

    assign w_big_step   = (w_delta32 > c_TOL_P) || (w_delta32 < c_TOL_N);
    assign w_flag_after = r_flag_q && !(w_idx_ok && w_big_step);

    always_comb begin
        w_state_d   = r_state_q;
        w_clr_ptr_d = r_clr_ptr_q;
        w_iter_d    = r_iter_q;
        w_conv_d    = r_conv_q;
        w_flag_d    = r_flag_q;
        w_y_valid_d = r_y_valid_q;
        w_y_idx_d   = r_y_idx_q;
        w_y_out_d   = r_y_out_q;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_d   = S_CLEAR;
                    w_clr_ptr_d = '0;
                    w_iter_d    = '0;
                    w_conv_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                w_clr_ptr_d = r_clr_ptr_q + 1'b1;
                if (r_clr_ptr_q == c_LAST_IDX) begin
                    w_clr_ptr_d = '0;
                    w_state_d   = S_RUN;
                    w_flag_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    w_flag_d = w_flag_after;
                    if (in_last) begin
                        if (r_iter_q != 8'hFF) begin
                            w_iter_d = r_iter_q + 8'd1;
                        end
                        w_conv_d = w_flag_after;
                        w_flag_d = 1'b1;
                        if (w_flag_after || (({1'b0, r_iter_q} + 9'd1) == c_MAX_ITER)) begin
                            w_state_d = S_DONE;
                        end
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        if (w_xfer) begin
            w_y_valid_d = 1'b1;
            w_y_idx_d   = in_idx;
            w_y_out_d   = w_y_new;
        end else if (y_ready) begin
            w_y_valid_d = 1'b0;
        end

        w_busy_d = (w_state_d == S_CLEAR) || (w_state_d == S_RUN);
        w_done_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_clr_ptr_q <= '0;
            r_iter_q    <= '0;
            r_conv_q    <= 1'b0;
            r_flag_q    <= 1'b0;
            r_y_valid_q <= 1'b0;
            r_y_idx_q   <= '0;
            r_y_out_q   <= '0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_clr_ptr_q <= w_clr_ptr_d;
            r_iter_q    <= w_iter_d;
            r_conv_q    <= w_conv_d;
            r_flag_q    <= w_flag_d;
            r_y_valid_q <= w_y_valid_d;
            r_y_idx_q   <= w_y_idx_d;
            r_y_out_q   <= w_y_out_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
        end
    end

    assign y_valid    = r_y_valid_q;
    assign y_idx      = r_y_idx_q;
    assign y_out      = r_y_out_q;
    assign iter_count = r_iter_q;
    assign converged  = r_conv_q;
    assign busy       = r_busy_q;
    assign done       = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_cell_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_cell_update
// Description : Scoreboard bench for cnn_cell_update (IDX_W widened, MAX_ITER=2).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cnn_cell_update;

    localparam int NUM_CELLS = 64;
    localparam int IDX_W     = 7;
    localparam int MAX_ITER  = 2;
    localparam int OOR_IDX   = 100;
    localparam int NO_EXP    = 32'h7fffffff;

    typedef struct {
        int idx;
        int y;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic [16:0]      in_sum;
    logic             in_last;
    logic             y_valid;
    logic             y_ready;
    logic [IDX_W-1:0] y_idx;
    logic [8:0]       y_out;
    logic [7:0]       iter_count;
    logic             converged;
    logic             busy;
    logic             done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    exp_t exp_q[$];
    int   model_x [NUM_CELLS];

    always #5 clk = ~clk;

    cnn_cell_update #(
        .NUM_CELLS (NUM_CELLS),
        .IDX_W     (IDX_W),
        .X_W       (20),
        .DT_SHIFT  (3),
        .Y_ONE     (128),
        .TOL       (2),
        .MAX_ITER  (MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_sum     (in_sum),
        .in_last    (in_last),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_idx      (y_idx),
        .y_out      (y_out),
        .iter_count (iter_count),
        .converged  (converged),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference Euler step with dt = 1/8, floor rounding written out explicitly.
    function automatic int model_step(input int idx, input int sum);
        int x, diff, delta, xn;
        x     = (idx < NUM_CELLS) ? model_x[idx] : 0;
        diff  = sum - x;
        delta = (diff >= 0) ? diff / 8 : -((-diff + 7) / 8);
        xn    = x + delta;
        if (xn > 524287)  xn = 524287;
        if (xn < -524288) xn = -524288;
        if (idx < NUM_CELLS) model_x[idx] = xn;
        if (xn > 128)  return 128;
        if (xn < -128) return -128;
        return xn;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && y_valid && y_ready) begin
            n_popped++;
            if (exp_q.size() == 0) begin
                check("y_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("y_idx", int'(y_idx), e.idx);
                check("y_out", int'($signed(y_out)), e.y);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Leaves in_valid asserted on return so consecutive calls are back-to-back.
    task automatic send(input int idx, input int sum, input bit last, input int exp_y);
        int   n;
        int   y_m;
        exp_t e;
        n        = 0;
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_sum   = 17'(sum);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            return;
        end
        y_m   = model_step(idx, sum);
        e.idx = idx;
        e.y   = (exp_y == NO_EXP) ? y_m : exp_y;
        exp_q.push_back(e);
        n_pushed++;
        @(posedge clk);
        #1;
        check("y_valid_lat", int'(y_valid), 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) model_x[i] = 0;
    endtask

    task automatic wait_run(output int n_cyc, output int n_busy);
        n_cyc  = 0;
        n_busy = 0;
        while (!in_ready && n_cyc < 200) begin
            if (busy) n_busy++;
            n_cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, nb;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_idx = '0;
        in_sum = '0; in_last = 1'b0; y_ready = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_conv", int'(converged), 0);
        check("rst_iter", int'(iter_count), 0);
        check("rst_y_idx", int'(y_idx), 0);
        check("rst_y_out", int'(y_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(2);
        check("idle_busy", int'(busy), 0);

        do_start();
        wait_run(nc, nb);
        check("clear_cycles", nc, 64);
        check("clear_busy", nb, 64);

        send(0, 800, 0, 100);
        send(0, 800, 0, 128);
        send(1, -9, 0, -2);
        idle(); cycles(2);

        send(63, 800, 0, 100);
        send(63, 800, 0, 128);
        send(OOR_IDX, 800, 0, 100);
        send(OOR_IDX, 800, 0, 100);
        idle(); cycles(2);

        // Stalled output with a new sum waiting upstream.
        y_ready = 1'b0;
        send(2, 400, 0, 50);
        in_valid = 1'b1; in_idx = IDX_W'(3); in_sum = 17'd80; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_y_valid", int'(y_valid), 1);
            check("bp_y_out", int'($signed(y_out)), 50);
            check("bp_y_idx", int'(y_idx), 2);
        end
        y_ready = 1'b1;
        send(3, 80, 0, 10);
        idle(); cycles(2);
        check("q_empty_pre_rst", exp_q.size(), 0);

        in_valid = 1'b1; in_idx = IDX_W'(5); in_sum = 17'd800;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_y_valid", int'(y_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_y_idx", int'(y_idx), 0);
        check("mid_rst_y_out", int'(y_out), 0);
        check("mid_rst_iter", int'(iter_count), 0);
        exp_q.delete();
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(2);

        do_start();
        wait_run(nc, nb);
        check("reclear_cycles", nc, 64);
        send(0, 800, 0, 100);
        for (int i = 1; i < NUM_CELLS; i++) send(i, 16000, i == NUM_CELLS - 1, NO_EXP);
        idle();
        check("sweep1_iter", int'(iter_count), 1);
        check("sweep1_conv", int'(converged), 0);
        check("sweep1_done", int'(done), 0);
        check("sweep1_busy", int'(busy), 1);
        for (int i = 0; i < NUM_CELLS; i++) send(i, 16000, i == NUM_CELLS - 1, NO_EXP);
        idle();
        check("maxit_iter", int'(iter_count), 2);
        check("maxit_conv", int'(converged), 0);
        check("maxit_done", int'(done), 1);
        check("maxit_busy", int'(busy), 0);
        check("maxit_in_ready", int'(in_ready), 0);
        cycles(2);

        do_start();
        check("restart_iter", int'(iter_count), 0);
        check("restart_busy", int'(busy), 1);
        check("restart_done", int'(done), 0);
        wait_run(nc, nb);
        check("clear3_cycles", nc, 64);
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (i == 32) send(OOR_IDX, 800, 0, 100);
            send(i, 0, i == NUM_CELLS - 1, 0);
        end
        idle();
        check("conv_iter", int'(iter_count), 1);
        check("conv_flag", int'(converged), 1);
        check("conv_done", int'(done), 1);
        check("conv_in_ready", int'(in_ready), 0);
        cycles(3);

        check("q_empty_end", exp_q.size(), 0);
        check("push_pop_match", n_popped, n_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
